// File: rtl/sat_narrow.sv
// ============================================================================
// Module   : sat_narrow
// Brief    : Combinational signed saturating narrow from IN_W to OUT_W bits,
//            with a flag that reports when the value was clipped.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clipped
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // In range only when every bit above the output sign bit copies it
            logic [IN_W-OUT_W:0] w_upper;
            logic                w_over;

            assign w_upper = din[IN_W-1:OUT_W-1];
            assign w_over  = ~((&w_upper) | (~|w_upper));
            assign clipped = w_over;
            assign dout    = !w_over         ? din[OUT_W-1:0] :
                             din[IN_W-1]     ? {1'b1, {(OUT_W-1){1'b0}}} :
                                               {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_widen
            assign dout    = OUT_W'(din);
            assign clipped = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/quad_velocity.sv
// ============================================================================
// Module   : quad_velocity
// Brief    : Samples a free-running encoder count every PERIOD cycles and
//            emits saturated per-period and moving-average velocities.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_velocity #(
    parameter int COUNT_WIDTH = 16,
    parameter int VEL_WIDTH   = 8,
    parameter int PERIOD      = 50000,
    parameter int AVG_LOG2    = 2
) (
    input  logic                        hba_clk,
    input  logic                        hba_reset,
    input  logic                        en,
    input  logic [COUNT_WIDTH-1:0]      count,
    input  logic                        sat_clr,
    output logic signed [VEL_WIDTH-1:0] vel,
    output logic signed [VEL_WIDTH-1:0] vel_avg,
    output logic                        vel_valid,
    output logic                        sat
);

    localparam int                 c_div_w    = $clog2(PERIOD);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(PERIOD - 1);
    localparam int                 c_depth    = 1 << AVG_LOG2;
    localparam int                 c_sum_w    = COUNT_WIDTH + AVG_LOG2;

    logic [c_div_w-1:0]            r_div;
    logic                          r_primed;
    logic [COUNT_WIDTH-1:0]        r_prev;
    logic signed [COUNT_WIDTH-1:0] r_hist [c_depth];
    logic signed [c_sum_w-1:0]     r_sum;
    logic signed [VEL_WIDTH-1:0]   r_vel;
    logic signed [VEL_WIDTH-1:0]   r_vel_avg;
    logic                          r_vel_valid;
    logic                          r_sat;

    logic                          w_tick;
    logic signed [COUNT_WIDTH-1:0] w_delta;
    logic signed [c_sum_w-1:0]     w_delta_ext;
    logic signed [c_sum_w-1:0]     w_oldest_ext;
    logic signed [c_sum_w-1:0]     w_sum_next;
    logic signed [c_sum_w-1:0]     w_avg;
    logic signed [VEL_WIDTH-1:0]   w_vel_sat;
    logic signed [VEL_WIDTH-1:0]   w_avg_sat;
    logic                          w_vel_clip;
    logic                          w_avg_clip;

    assign w_tick = en & (r_div == c_div_last);

    // Modular subtraction makes encoder wrap-around come out as a small delta
    assign w_delta      = count - r_prev;
    assign w_delta_ext  = {{AVG_LOG2{w_delta[COUNT_WIDTH-1]}}, w_delta};
    assign w_oldest_ext = {{AVG_LOG2{r_hist[c_depth-1][COUNT_WIDTH-1]}}, r_hist[c_depth-1]};
    assign w_sum_next   = r_sum + w_delta_ext - w_oldest_ext;
    assign w_avg        = w_sum_next >>> AVG_LOG2;

    sat_narrow #(
        .IN_W  (COUNT_WIDTH),
        .OUT_W (VEL_WIDTH)
    ) u_sat_vel (
        .din     (w_delta),
        .dout    (w_vel_sat),
        .clipped (w_vel_clip)
    );

    sat_narrow #(
        .IN_W  (c_sum_w),
        .OUT_W (VEL_WIDTH)
    ) u_sat_avg (
        .din     (w_avg),
        .dout    (w_avg_sat),
        .clipped (w_avg_clip)
    );

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_div       <= '0;
            r_primed    <= 1'b0;
            r_prev      <= '0;
            r_sum       <= '0;
            r_vel       <= '0;
            r_vel_avg   <= '0;
            r_vel_valid <= 1'b0;
            r_sat       <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_vel_valid <= 1'b0;
            if (sat_clr) begin
                r_sat <= 1'b0;
            end

            if (!en) begin
                r_div    <= '0;
                r_primed <= 1'b0;
            end else if (w_tick) begin
                r_div  <= '0;
                r_prev <= count;
                if (!r_primed) begin
                    r_primed <= 1'b1;
                    r_sum    <= '0;
                    for (int i = 0; i < c_depth; i++) begin
                        r_hist[i] <= '0;
                    end
                end else begin
                    for (int i = c_depth - 1; i > 0; i--) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                    r_hist[0]   <= w_delta;
                    r_sum       <= w_sum_next;
                    r_vel       <= w_vel_sat;
                    r_vel_avg   <= w_avg_sat;
                    r_vel_valid <= 1'b1;
                    // A clip on this tick overrides a simultaneous clear
                    if (w_vel_clip || w_avg_clip) begin
                        r_sat <= 1'b1;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign vel       = r_vel;
    assign vel_avg   = r_vel_avg;
    assign vel_valid = r_vel_valid;
    assign sat       = r_sat;

endmodule

`default_nettype wire

// File: doc/quad_velocity.md
# quad_velocity

Downstream consumer of the quadrature encoder count path: samples a free-running 16-bit encoder count (the `pulse_counter` output inside the quad peripheral) at a fixed sample period. Produces a signed per-period velocity and a moving-average velocity, both saturated to 8 bits, with a one-cycle valid strobe. Sits between the encoder counter and the motor speed-control / HBA register stage, one instance per wheel.

## Interface
Parameters:
- `COUNT_WIDTH`, default 16: width of the input encoder count.
- `VEL_WIDTH`, default 8: width of the signed velocity outputs.
- `PERIOD`, default 50000: clock cycles per sample; legal range ≥ 2.
- `AVG_LOG2`, default 2: the average window is 2^AVG_LOG2 samples; legal range 1..4.

Ports:
- `hba_clk`, in, 1: the single clock.
- `hba_reset`, in, 1: synchronous, active-high reset.
- `en`, in, 1: sampling enable.
- `count`, in, COUNT_WIDTH: encoder count, treated as modulo 2^COUNT_WIDTH.
- `sat_clr`, in, 1: clears the sticky `sat` flag.
- `vel`, out, VEL_WIDTH: signed delta over the last period, saturated.
- `vel_avg`, out, VEL_WIDTH: signed mean of the last 2^AVG_LOG2 deltas, saturated.
- `vel_valid`, out, 1: one-cycle strobe; `vel` and `vel_avg` are new.
- `sat`, out, 1: sticky flag; some output was clipped.

## Operation
- Reset values:
  - `vel`=0, `vel_avg`=0, `vel_valid`=0, `sat`=0.
  - Prescaler=0, history cleared, `primed`=0.
- Prescaler `div`:
  - Increments each cycle while `en`=1.
  - The cycle with `div`==PERIOD-1 is a tick; `div` then returns to 0.
  - While `en`=0: `div` is forced to 0, `primed` is cleared, outputs hold their values, `vel_valid`=0.
- Tick with `primed`=0 (priming):
  - `prev`<=`count`, history cleared to zero, `primed`<=1.
  - No `vel_valid`.
- Tick with `primed`=1:
  - Delta: `delta = count - prev`, computed modulo 2^COUNT_WIDTH and read as signed. Encoder wrap 0xFFFE→0x0003 gives +5.
  - `prev`<=`count`.
  - History: `delta` is pushed into a 2^AVG_LOG2-deep shift register of full-width signed deltas; the oldest entry is dropped.
  - Running sum: width COUNT_WIDTH+AVG_LOG2, updated as `sum + delta - oldest` (no re-summing).
  - `vel`: `delta` saturated to [-2^(VEL_WIDTH-1), 2^(VEL_WIDTH-1)-1].
  - `vel_avg`: (new sum >>> AVG_LOG2), an arithmetic shift that floors toward −∞, then saturated the same way.
  - Immediately after priming, the history holds zeros, so `vel_avg` ramps up over the first 2^AVG_LOG2 valid samples.
  - `vel_valid`=1 for exactly one cycle.
- `sat` flag:
  - Set on any valid tick where `vel` or `vel_avg` clipped.
  - `sat_clr` clears it; if set and clear occur in the same cycle, set wins.
- `en` rising: the first tick afterwards is a priming tick.
- `hba_reset` mid-period: everything returns to reset values on the next edge; any in-flight sample is discarded.

## Timing
- The tick occurs PERIOD cycles after `en` rises (or after reset release, if `en` is already high).
- `count` is sampled at the rising edge that ends the tick cycle.
- `vel`, `vel_avg` and `vel_valid` are registered on that same edge: the strobe is high in cycle tick+1 and coincides with the new output values.
- Strobe spacing is exactly PERIOD cycles while `en`=1.
- Latency from a `count` change to its reflection in `vel` is at most PERIOD+1 cycles.
- No backpressure: the consumer must accept data on `vel_valid`. The values hold until the next strobe.

## Structure
- No shared package is needed; all widths derive from the parameters.
- One sub-module, `sat_narrow` (parameters IN_W, OUT_W): combinational signed saturate that returns the narrowed value and a `clipped` bit. It is instantiated twice, for `vel` and `vel_avg`.
- The top level holds the prescaler, `primed`, `prev`, the history shift register, the running-sum register and the output registers.

## Test plan
All scenarios use PERIOD=8, AVG_LOG2=2.
- **Reset/priming:** release reset with `en`=1 and `count`=100.
  - First tick: no strobe.
  - Set `count`=103; next tick gives `vel`=3, `vel_avg`=0 (3>>>2). Strobe is one cycle, 8 cycles after the previous tick.
- **Wrap-around:** `prev`=0xFFFE, `count`=0x0003 → `vel`=+5. Reverse direction 0x0003→0xFFFE → `vel`=−5.
- **Saturation:** delta +300 → `vel`=127, `sat`=1. `sat_clr` pulse → `sat`=0. Delta −200 together with `sat_clr` in the same cycle → `sat`=1 (set wins), `vel`=−128.
- **Average:** constant delta 10 for 5 valid ticks → `vel_avg` = 2, 5, 7, 10, 10. Then delta −6 once → `vel_avg`=6 (24>>>2). A case that exercises flooring of a negative sum: sum −5 → `vel_avg`=−2.
- **Enable gating:**
  - Drop `en` mid-period: no strobes; outputs hold.
  - Re-raise `en`: the first tick primes (no strobe); valid data resumes PERIOD cycles later with `vel_avg` history cleared.
- **Reset mid-operation:** assert `hba_reset` for one cycle at `div`=5 → all outputs 0 next cycle, and the following tick primes.
